pc_unit: RTL and testbench



---
 rtl/pc_unit_pkg.sv | 24 ++
 rtl/pc_unit_redirect_buf.sv | 31 +++
 rtl/pc_unit.sv | 117 +++++++++++
 tb/tb_pc_unit.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
// Shared fetch-stage definitions: control encodings, default reset vector
// and the PC sequencer state type.
package pc_unit_pkg;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic FLUSH        = 1'b1;
  localparam logic STOP         = 1'b1;
  localparam logic NO_STOP      = 1'b0;
  localparam logic DO_BRANCH    = 1'b1;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_3000;

  // state | meaning
  // OFF   | fetch disabled (ce=0), pc parked on the reset vector
  // RUN   | fetching, no redirect waiting
  // PEND  | fetching but stalled with a captured branch target waiting
  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_unit_redirect_buf.sv
// One-entry pending-redirect buffer: holds a branch target captured while
// fetch is stalled until the sequencer consumes or discards it.
import pc_unit_pkg::*;

module pc_redirect_buf #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              clear,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              valid,
  output logic [ADDR_W-1:0] addr
);

  // Clear wins over capture so a flush in the same cycle leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      addr  <= '0;
    end else if (capture) begin
      valid <= 1'b1;
      addr  <= addr_in;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage PC sequencer: produces the instruction fetch address and chip
// enable, with flush/branch redirects and a one-entry buffer for branches
// that arrive while fetch is stalled.
import pc_unit_pkg::*;

module pc_unit #(
  parameter int unsigned ADDR_W       = 32,
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int unsigned INST_BYTES   = 4,
  parameter int unsigned STALL_W      = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  new_pc,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_addr_i,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic               redirect_pending_o,
  output logic               pc_misalign_o
);

  localparam logic [ADDR_W-1:0] RV   = ADDR_W'(RESET_VECTOR);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INST_BYTES);

  pc_state_e         state, state_next;
  logic [ADDR_W-1:0] pc_next;
  logic              buf_capture, buf_clear;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic              stall_unused;

  // Only the fetch-stage bit of the stall vector matters here.
  assign stall_unused = ^stall[STALL_W-1:0];

  pc_redirect_buf #(.ADDR_W(ADDR_W)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .capture (buf_capture),
    .clear   (buf_clear),
    .addr_in (branch_addr_i),
    .valid   (pend_valid),
    .addr    (pend_addr)
  );

  // State, pc and chip-enable registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_OFF;
      pc    <= RV;
      ce    <= CHIP_DISABLE;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      ce    <= (state_next == ST_OFF) ? CHIP_DISABLE : CHIP_ENABLE;
    end
  end

  // Next-state and next-pc selection in redirect priority order.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    buf_capture = 1'b0;
    buf_clear   = 1'b0;
    case (state)
      ST_OFF: begin
        state_next = ST_RUN;
        pc_next    = RV;
        buf_clear  = 1'b1;
      end
      ST_RUN, ST_PEND: begin
        if (flush == FLUSH) begin
          pc_next    = new_pc;
          buf_clear  = 1'b1;
          state_next = ST_RUN;
        end else if (stall[0] == STOP) begin
          // Only the first target captured during a stall is kept.
          if (branch_flag_i == DO_BRANCH && state == ST_RUN) begin
            buf_capture = 1'b1;
            state_next  = ST_PEND;
          end
        end else if (branch_flag_i == DO_BRANCH) begin
          // A fresh decode request supersedes a stale pending one.
          pc_next    = branch_addr_i;
          buf_clear  = 1'b1;
          state_next = ST_RUN;
        end else if (state == ST_PEND) begin
          pc_next    = pend_addr;
          buf_clear  = 1'b1;
          state_next = ST_RUN;
        end else begin
          pc_next = pc + STEP;
        end
      end
      default: begin
        state_next = ST_OFF;
        pc_next    = RV;
        buf_clear  = 1'b1;
      end
    endcase
  end

  assign redirect_pending_o = pend_valid;

  // Misalignment is flagged from the low address bits; byte-granular fetch never misaligns.
  generate
    if (INST_BYTES <= 1) begin : g_no_align
      assign pc_misalign_o = 1'b0;
    end else begin : g_align
      localparam logic [ADDR_W-1:0] MASK = ADDR_W'(INST_BYTES - 1);
      assign pc_misalign_o = |(pc & MASK);
    end
  endgenerate

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus pushes the expected post-edge
// outputs computed by a behavioural model; a monitor pops and compares.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_addr_i;
  logic [31:0] pc;
  logic        ce;
  logic        redirect_pending_o;
  logic        pc_misalign_o;

  typedef struct {
    logic        ce;
    logic [31:0] pc;
    logic        pend;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic        m_on;
  logic [31:0] m_pc;
  logic        m_pv;
  logic [31:0] m_pa;

  pc_unit dut (
    .clk                (clk),
    .rst                (rst),
    .stall              (stall),
    .flush              (flush),
    .new_pc             (new_pc),
    .branch_flag_i      (branch_flag_i),
    .branch_addr_i      (branch_addr_i),
    .pc                 (pc),
    .ce                 (ce),
    .redirect_pending_o (redirect_pending_o),
    .pc_misalign_o      (pc_misalign_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive on the falling edge, update the model, push the expectation.
  task automatic step(input logic r, input logic [5:0] st, input logic fl, input logic [31:0] npc,
                      input logic br, input logic [31:0] ba);
    exp_t e;
    @(negedge clk);
    rst = r; stall = st; flush = fl; new_pc = npc; branch_flag_i = br; branch_addr_i = ba;
    if (r) begin
      m_on = 1'b0; m_pc = 32'h0000_3000; m_pv = 1'b0; m_pa = 32'h0;
    end else if (!m_on) begin
      m_on = 1'b1; m_pc = 32'h0000_3000;
    end else if (fl) begin
      m_pc = npc; m_pv = 1'b0;
    end else if (st[0]) begin
      if (br && !m_pv) begin m_pv = 1'b1; m_pa = ba; end
    end else if (br) begin
      m_pc = ba; m_pv = 1'b0;
    end else if (m_pv) begin
      m_pc = m_pa; m_pv = 1'b0;
    end else begin
      m_pc = m_pc + 32'd4;
    end
    e.ce = m_on; e.pc = m_pc; e.pend = m_pv; e.mis = (m_pc[1:0] != 2'b00);
    q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 6'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Monitor: after each rising edge compare the DUT against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("ce", {31'b0, ce}, {31'b0, e.ce});
        check("pc", pc, e.pc);
        check("pending", {31'b0, redirect_pending_o}, {31'b0, e.pend});
        check("misalign", {31'b0, pc_misalign_o}, {31'b0, e.mis});
      end
    end
  end

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0; new_pc = '0; branch_flag_i = 1'b0; branch_addr_i = '0;
    m_on = 1'b0; m_pc = 32'h0000_3000; m_pv = 1'b0; m_pa = 32'h0;

    // Reset then start-up sequence 0x3000, 0x3004, 0x3008
    step(1'b1, 6'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 6'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (4) idle();
    // Branch unstalled
    step(1'b0, 6'h0, 1'b0, 32'h0, 1'b1, 32'h0000_3100);
    idle();
    // Branch during stall: first target kept, second ignored, third stall cycle plain
    step(1'b0, 6'h1, 1'b0, 32'h0, 1'b1, 32'h0000_4000);
    step(1'b0, 6'h3, 1'b0, 32'h0, 1'b1, 32'h0000_5000);
    step(1'b0, 6'h1, 1'b0, 32'h0, 1'b0, 32'h0);
    idle();
    idle();
    // Flush beats a pending redirect, stall and branch
    step(1'b0, 6'h1, 1'b0, 32'h0, 1'b1, 32'h0000_4000);
    step(1'b0, 6'h1, 1'b1, 32'h0000_0180, 1'b1, 32'h0000_7000);
    step(1'b0, 6'h1, 1'b0, 32'h0, 1'b0, 32'h0);
    idle();
    // Wrap-around and misalignment flag
    step(1'b0, 6'h0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8);
    idle();
    idle();
    idle();
    step(1'b0, 6'h0, 1'b0, 32'h0, 1'b1, 32'h0000_3002);
    idle();
    // Newer unstalled branch wins over a stale pending target
    step(1'b0, 6'h1, 1'b0, 32'h0, 1'b1, 32'h0000_6000);
    step(1'b0, 6'h0, 1'b0, 32'h0, 1'b1, 32'h0000_6100);
    idle();
    // Reset while pending: old target never fetched
    step(1'b0, 6'h1, 1'b0, 32'h0, 1'b1, 32'h0000_8000);
    step(1'b1, 6'h1, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (4) idle();

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      logic        r, fl, br;
      logic [5:0]  st;
      logic [31:0] npc, ba;
      r   = ($urandom_range(0, 99) < 2);
      st  = 6'($urandom);
      st[0] = ($urandom_range(0, 99) < 40);
      fl  = ($urandom_range(0, 99) < 6);
      br  = ($urandom_range(0, 99) < 30);
      npc = $urandom;
      ba  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        npc[1:0] = 2'b00;
        ba[1:0]  = 2'b00;
      end
      step(r, st, fl, npc, br, ba);
    end

    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
